// File: rtl/init_sequencer_if.sv
// -----------------------------------------------------------------------------
// init_sequencer_if
// Bundles the sequencer's stage-control and status signals.
//
// Signals:
//   stage_ready_i [NUM_STAGES]  per-stage ready/locked level (may be async)
//   restart_req                 single-cycle clk-domain pulse, full re-sequence
//   stage_rst_o   [NUM_STAGES]  per-stage active-high reset
//   sys_ready                   whole chain is up
//   init_fail                   retries exhausted (sticky)
//   retry_cnt                   faults taken since last restart
//   cur_stage                   index of the stage currently awaited
//
// Handshake: there is no valid/ready transfer on this bundle. Every signal is
// a level. stage_ready_i is treated as asynchronous and synchronized inside the
// sequencer. restart_req is sampled on each rising clk edge and acts on the
// edge where it is high. All outputs change only on clk edges, except that
// rst forces them to their reset values immediately.
//
// Modports:
//   slave  - the sequencer (consumes ready/restart, drives resets/status)
//   master - the environment (drives ready/restart, observes resets/status)
// -----------------------------------------------------------------------------
interface init_sequencer_if #(
    parameter int NUM_STAGES  = 4,
    parameter int MAX_RETRIES = 3
);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int CW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    logic [NUM_STAGES-1:0] stage_ready_i;
    logic                  restart_req;
    logic [NUM_STAGES-1:0] stage_rst_o;
    logic                  sys_ready;
    logic                  init_fail;
    logic [RW-1:0]         retry_cnt;
    logic [CW-1:0]         cur_stage;

    modport slave (
        input  stage_ready_i,
        input  restart_req,
        output stage_rst_o,
        output sys_ready,
        output init_fail,
        output retry_cnt,
        output cur_stage
    );

    modport master (
        output stage_ready_i,
        output restart_req,
        input  stage_rst_o,
        input  sys_ready,
        input  init_fail,
        input  retry_cnt,
        input  cur_stage
    );
endinterface

// File: rtl/init_sequencer.sv
// -----------------------------------------------------------------------------
// init_sequencer
// Brings up the feed-handler datapath stages in index order. All stage resets
// are held for HOLD_CYCLES, then stage 0 is released; each further stage is
// released once the previous one reports ready. Every wait has a timeout, a
// fault (timeout or a released stage dropping ready) triggers a full
// re-sequence, and after MAX_RETRIES re-sequences the next fault parks the
// block in FAIL until restart_req or rst.
//
// Ports:
//   clk          fabric clock
//   rst          asynchronous active-high reset
//   bus          init_sequencer_if.slave (ready/restart in, resets/status out)
//   o_dbg_state  current FSM state (0=HOLD, 1=WAIT, 2=RUN, 3=FAIL)
// -----------------------------------------------------------------------------
module init_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    init_sequencer_if.slave        bus,
    output logic [1:0]             o_dbg_state
);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam int CW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_HOLD = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_sync1;
    logic [NUM_STAGES-1:0] r_sync2;
    logic [HW-1:0]         r_hold_cnt;
    logic [TW-1:0]         r_timer;
    logic [NUM_STAGES-1:0] r_stage_rst;
    logic                  r_sys_ready;
    logic                  r_init_fail;
    logic [RW-1:0]         r_retry_cnt;
    logic [CW-1:0]         r_cur_stage;

    logic [NUM_STAGES-1:0] w_rdy_s;
    logic [NUM_STAGES-1:0] w_lower_mask;   // stages released before the current one
    logic [NUM_STAGES-1:0] w_next_onehot;  // stage to release after the current one
    logic                  w_cur_rdy;
    logic                  w_lower_drop;
    logic                  w_last;
    logic                  w_timeout;
    logic                  w_hold_done;
    logic                  w_fault;

    assign w_rdy_s = r_sync2;

    always_comb begin
        w_lower_mask  = '0;
        w_next_onehot = '0;
        w_cur_rdy     = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            w_lower_mask[i]  = (CW'(i) < r_cur_stage);
            w_next_onehot[i] = (CW'(i) == r_cur_stage + 1'b1);
            if (CW'(i) == r_cur_stage) begin
                w_cur_rdy = w_rdy_s[i];
            end
        end
    end

    assign w_lower_drop = |(w_lower_mask & ~w_rdy_s);
    assign w_last       = (r_cur_stage == CW'(NUM_STAGES - 1));
    assign w_timeout    = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_hold_done  = (r_hold_cnt == HW'(HOLD_CYCLES - 1));

    // A ready on the awaited stage beats a timeout on the same cycle, but a
    // released stage losing ready always faults.
    assign w_fault = ((r_state == S_WAIT) && ((!w_cur_rdy && w_timeout) || w_lower_drop))
                   || ((r_state == S_RUN) && !(&w_rdy_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HOLD;
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_hold_cnt  <= '0;
            r_timer     <= '0;
            r_stage_rst <= '1;
            r_sys_ready <= 1'b0;
            r_init_fail <= 1'b0;
            r_retry_cnt <= '0;
            r_cur_stage <= '0;
        end else begin
            r_sync1 <= bus.stage_ready_i;
            r_sync2 <= r_sync1;

            if (bus.restart_req) begin
                r_state     <= S_HOLD;
                r_hold_cnt  <= '0;
                r_timer     <= '0;
                r_stage_rst <= '1;
                r_sys_ready <= 1'b0;
                r_init_fail <= 1'b0;
                r_retry_cnt <= '0;
                r_cur_stage <= '0;
            end else if (w_fault) begin
                // Fault is resolved on the detecting edge: retry or give up.
                r_hold_cnt  <= '0;
                r_timer     <= '0;
                r_stage_rst <= '1;
                r_sys_ready <= 1'b0;
                r_cur_stage <= '0;
                if (r_retry_cnt < RW'(MAX_RETRIES)) begin
                    r_retry_cnt <= r_retry_cnt + 1'b1;
                    r_state     <= S_HOLD;
                end else begin
                    r_init_fail <= 1'b1;
                    r_state     <= S_FAIL;
                end
            end else begin
                case (r_state)
                    S_HOLD: begin
                        if (w_hold_done) begin
                            r_state        <= S_WAIT;
                            r_hold_cnt     <= '0;
                            r_timer        <= '0;
                            r_cur_stage    <= '0;
                            r_stage_rst[0] <= 1'b0;
                        end else begin
                            r_hold_cnt <= r_hold_cnt + 1'b1;
                        end
                    end
                    S_WAIT: begin
                        if (w_cur_rdy) begin
                            r_timer <= '0;
                            if (w_last) begin
                                r_state     <= S_RUN;
                                r_sys_ready <= 1'b1;
                            end else begin
                                r_cur_stage <= r_cur_stage + 1'b1;
                                r_stage_rst <= r_stage_rst & ~w_next_onehot;
                            end
                        end else begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_stage_rst <= '0;
                        r_sys_ready <= 1'b1;
                    end
                    S_FAIL: begin
                        r_stage_rst <= '1;
                        r_sys_ready <= 1'b0;
                        r_init_fail <= 1'b1;
                    end
                    default: begin
                        r_state <= S_HOLD;
                    end
                endcase
            end
        end
    end

    assign bus.stage_rst_o = r_stage_rst;
    assign bus.sys_ready   = r_sys_ready;
    assign bus.init_fail   = r_init_fail;
    assign bus.retry_cnt   = r_retry_cnt;
    assign bus.cur_stage   = r_cur_stage;
    assign o_dbg_state     = r_state;
endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
- Consumes the fabric `rst` produced by the power-on reset stretcher and brings up the feed-handler datapath in a fixed order.
- Holds per-stage resets for the MAC, parser, book builder, egress and similar stages. Releases them one at a time and waits for each stage's ready before releasing the next.
- Enforces a per-stage timeout with bounded retries.
- Reports `sys_ready` when the whole chain is up, and `init_fail` when retries are exhausted.

Parameters:
- NUM_STAGES, 4, number of sequenced stages (1..16); stage 0 is released first.
- HOLD_CYCLES, 16, cycles all stage resets are held asserted before stage 0 is released (≥1).
- TIMEOUT_CYCLES, 1024, max cycles to wait for a released stage's ready (≥4).
- MAX_RETRIES, 3, full re-sequence attempts allowed after a fault before declaring failure (≥0).

Ports:
- clk  input  1  fabric clock (125 MHz)
- rst  input  1  asynchronous, active-high reset; driven by the reset stretcher
- stage_ready_i  input  NUM_STAGES  per-stage ready/locked; may be asynchronous; level-sensitive
- restart_req  input  1  single-cycle pulse in clk domain; forces a full re-sequence
- stage_rst_o  output  NUM_STAGES  per-stage active-high reset, registered
- sys_ready  output  1  all stages up, registered
- init_fail  output  1  retries exhausted, sticky until restart_req or rst
- retry_cnt  output  max(1,$clog2(MAX_RETRIES+1))  faults taken since last restart
- cur_stage  output  max(1,$clog2(NUM_STAGES))  stage currently awaited (index)

Behaviour:
- Reset values (rst high, asynchronous):
  - state=HOLD, hold/timeout counters=0.
  - stage_rst_o=all 1s, sys_ready=0, init_fail=0, retry_cnt=0, cur_stage=0.
  - Synchronizer flops=0.
- Input synchronization:
  - stage_ready_i passes through a 2-flop synchronizer per bit; rdy_s is the synchronized value.
  - An input change before edge E is seen by the FSM at edge E+1 and acted on at edge E+2.
- HOLD:
  - All stage_rst_o=1, sys_ready=0.
  - Counter runs 0..HOLD_CYCLES-1.
  - On the edge where counter==HOLD_CYCLES-1: go to WAIT, set cur_stage=0, clear stage_rst_o[0], clear timer.
- WAIT(k):
  - Timer increments every cycle.
  - If rdy_s[k]=1:
    - If k<NUM_STAGES-1: set cur_stage=k+1, clear stage_rst_o[k+1], clear timer, stay in WAIT.
    - If k==NUM_STAGES-1: go to RUN and set sys_ready=1 on the same edge.
  - If rdy_s[k]=0 and timer==TIMEOUT_CYCLES-1: FAULT.
  - If rdy_s[j]=0 for any already-released j<k: FAULT.
  - Ready and timeout on the same cycle: ready wins.
- RUN:
  - sys_ready=1; all stage_rst_o=0.
  - Any rdy_s bit falling to 0 triggers FAULT; sys_ready clears on that edge.
- FAULT (evaluated on the same edge that detects the fault, no extra state cycle):
  - If retry_cnt<MAX_RETRIES: retry_cnt+1, reassert all stage_rst_o, go to HOLD with counter=0.
  - Otherwise: go to FAIL.
- FAIL:
  - All stage_rst_o=1, init_fail=1, sys_ready=0.
  - Remains until restart_req or rst.
- restart_req (any state, highest priority below rst):
  - Go to HOLD with counter=0, retry_cnt=0, init_fail=0, all stage_rst_o=1, sys_ready=0, cur_stage=0.
- Invariants:
  - stage_rst_o[i]=0 implies stage_rst_o[j]=0 for all j<i; release is strictly in index order.
  - sys_ready=1 only when stage_rst_o is all 0s.
- rst asserted mid-sequence: all outputs return to reset values immediately (asynchronous). Sequencing restarts from HOLD on the first edge after rst deasserts.
- Counter widths:
  - Hold counter: $clog2(HOLD_CYCLES).
  - Timer: $clog2(TIMEOUT_CYCLES).
  - Neither wraps: both are cleared on every state or stage change.
- retry_cnt saturates at MAX_RETRIES.

Test Plan (NUM_STAGES=3, HOLD_CYCLES=8, TIMEOUT_CYCLES=64, MAX_RETRIES=2):
- Nominal bring-up:
  - Stimulus: deassert rst; drive each stage_ready_i[k] high 5 cycles after its stage_rst_o[k] falls.
  - Required: stage_rst_o[0] falls on the 8th edge after rst deassert; stages 1 and 2 follow in order, each 7 edges after the previous stage's reset falls (5-cycle stage response + 2-edge sync latency); sys_ready rises on the edge after stage 2's ready is seen; retry_cnt=0.
- Timeout then retry:
  - Stimulus: hold stage_ready_i[1]=0.
  - Required: 64 cycles after stage_rst_o[1] falls, all resets reassert and retry_cnt=1; the 8-cycle HOLD repeats; a second timeout gives retry_cnt=2.
- Exhaustion:
  - Stimulus: stage 1 never ready.
  - Required: after the 3rd timeout, init_fail=1 and stage_rst_o=3'b111, held for 200+ cycles; restart_req pulse clears init_fail and retry_cnt=0, and HOLD restarts.
- Run-time fault:
  - Stimulus: reach RUN, then drop stage_ready_i[0] for 1 cycle.
  - Required: sys_ready falls 2 edges later, stage_rst_o=3'b111, retry_cnt=1, then full re-sequence to sys_ready.
- Boundary:
  - Stimulus: ready for stage 0 arrives at the synchronizer output exactly when timer==63.
  - Required: stage advances, no retry.
  - Stimulus: earlier stage 0 ready drops while in WAIT(2).
  - Required: FAULT.
- Async reset mid-sequence:
  - Stimulus: assert rst between clock edges during WAIT(1).
  - Required: stage_rst_o=3'b111 before the next edge, and all other outputs return to their reset values.
